logic_unit_arbiter: RTL and testbench

- Shares one registered WIDTH-bit logic unit (AND/OR/XOR/NAND) between two requesters.
- Uses a request/grant/done handshake with round-robin priority.
- Sits between the two client blocks and the shared gate datapath. It sequences operand capture, evaluation and result delivery.
- It is the control layer over the combinational gate modules.

---
 rtl/logic_unit_arbiter.sv | 141 ++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Shares one registered WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND)
//   between two requesters.  A request seen in IDLE captures that
//   requester's operands and pulses its gnt.  The next cycle evaluates the
//   captured operands into `result` and pulses the owner's done.  One more
//   cycle returns the FSM to IDLE, so a new grant is possible every third
//   cycle.  When both requesters ask at once, the one that was not served
//   last wins.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   req0/req1      requests, held by the client until its gnt is seen
//   a0,b0,op0      requester 0 operands and opcode
//   a1,b1,op1      requester 1 operands and opcode
//   gnt0/gnt1      one-cycle pulse: operands captured
//   done0/done1    one-cycle pulse: result valid for that requester
//   result         last computed result, held between operations
//   busy           high whenever the FSM is not in IDLE
//
// Opcodes: 00 AND, 01 OR, 10 XOR, 11 NAND.
module logic_unit_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [1:0]         op_p0;
  logic               owner;
  logic               last_owner;

  function automatic logic [WIDTH-1:0] gate_eval(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  // Requester 0 wins when it is alone or when a tie goes its way
  // (requester 1 was served last).
  logic pick0;
  logic pick1;
  assign pick0 = req0 && (!req1 || last_owner);
  assign pick1 = req1 && !pick0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      result     <= '0;
      a_p0       <= '0;
      b_p0       <= '0;
      op_p0      <= 2'b00;
      owner      <= 1'b0;
      last_owner <= 1'b1;
    end else begin
      // Pulses default low; each state raises only the one it owns.
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        // Stage p0: arbitration and operand capture.
        IDLE: begin
          if (pick0) begin
            a_p0       <= a0;
            b_p0       <= b0;
            op_p0      <= op0;
            owner      <= 1'b0;
            last_owner <= 1'b0;
            gnt0       <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end else if (pick1) begin
            a_p0       <= a1;
            b_p0       <= b1;
            op_p0      <= op1;
            owner      <= 1'b1;
            last_owner <= 1'b1;
            gnt1       <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        // Stage p1: evaluate captured operands, route done to the owner.
        EXEC: begin
          result <= gate_eval(a_p0, b_p0, op_p0);
          done0  <= ~owner;
          done1  <= owner;
          state  <= DONE;
        end
        // Stage p2: recovery cycle; requests are not sampled here.
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   op0, op1;
  logic         gnt0, gnt1, done0, done1, busy;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic_unit_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: a schedule of when the current operation's grant and
  // done land, plus the earliest cycle a new request can be accepted.
  int           gnt_at, done_at, free_at;
  bit           m_owner, m_last;
  logic [W-1:0] m_pending, m_result;
  logic [W+4:0] exp_out;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, b, input logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  task automatic model_reset();
    gnt_at = -10; done_at = -10; free_at = 0;
    m_owner = 1'b0; m_last = 1'b1;
    m_pending = '0; m_result = '0;
    exp_out = '0;
  endtask

  task automatic model_edge(input int k);
    bit win;
    if (k == done_at) m_result = m_pending;
    if (k >= free_at && (req0 || req1)) begin
      win = (req0 && req1) ? !m_last : req1;
      m_pending = win ? ref_op(a1, b1, op1) : ref_op(a0, b0, op0);
      gnt_at = k; done_at = k + 1; free_at = k + 3;
      m_owner = win; m_last = win;
    end
    exp_out = {(k == gnt_at) && !m_owner, (k == gnt_at) && m_owner,
               (k == done_at) && !m_owner, (k == done_at) && m_owner,
               (k == gnt_at) || (k == done_at), m_result};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  function automatic logic [W+4:0] outs();
    return {gnt0, gnt1, done0, done1, busy, result};
  endfunction

  // One clock edge with the model advanced on the same inputs.
  task automatic step();
    model_edge(cyc);
    @(posedge clk); #1;
    cyc++;
    chk("model_outs", 32'(outs()), 32'(exp_out));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("reset_outs", 32'(outs()), 32'd0);
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
  endtask

  // Single request from requester `who`; returns the observed result.
  task automatic do_op(input bit who, input logic [W-1:0] a, b, input logic [1:0] op,
                       output logic [W-1:0] res);
    bit seen;
    seen = 1'b0;
    if (who) begin a1 = a; b1 = b; op1 = op; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; op0 = op; req0 = 1'b1; end
    for (int i = 0; i < 8 && !seen; i++) begin
      step();
      if (gnt0 || gnt1) seen = 1'b1;
    end
    if (!seen) chk("gnt_timeout", 32'd0, 32'd1);
    chk("gnt_route", 32'({gnt0, gnt1}), who ? 32'd1 : 32'd2);
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("done_route", 32'({done0, done1}), who ? 32'd1 : 32'd2);
    res = result;
    step();
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] expv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [W-1:0] r;
    int order[$];
    bit seen;

    tbl[0] = '{4'b1100, 4'b1010, 2'd0, 4'b1000};
    tbl[1] = '{4'b1100, 4'b1010, 2'd1, 4'b1110};
    tbl[2] = '{4'b1100, 4'b1010, 2'd2, 4'b0110};
    tbl[3] = '{4'b1100, 4'b1010, 2'd3, 4'b0111};
    tbl[4] = '{4'b1111, 4'b0000, 2'd0, 4'b0000};
    tbl[5] = '{4'b0000, 4'b0000, 2'd1, 4'b0000};
    tbl[6] = '{4'b1111, 4'b0101, 2'd2, 4'b1010};
    tbl[7] = '{4'b0000, 4'b0000, 2'd3, 4'b1111};

    req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
    do_reset();

    // First operation: gnt0, then done0 with AND result, busy for 2 cycles.
    a0 = 4'b1100; b0 = 4'b1010; op0 = 2'd0; req0 = 1'b1;
    step();
    chk("first_gnt0_busy", 32'({gnt0, done0, busy}), 32'b101);
    req0 = 1'b0;
    step();
    chk("first_done0", 32'({gnt0, done0, busy, result}), 32'b011_1000);
    step();
    chk("first_idle", 32'({gnt0, done0, busy, result}), 32'b000_1000);

    // Opcode table, alternating requesters.
    foreach (tbl[i]) begin
      do_op(i[0], tbl[i].a, tbl[i].b, tbl[i].op, r);
      chk($sformatf("tbl%0d", i), 32'(r), 32'(tbl[i].expv));
    end

    // Both held from reset: order 0,1,0,1.
    do_reset();
    a0 = 4'b0011; b0 = 4'b0101; op0 = 2'd1;
    a1 = 4'b0011; b1 = 4'b0101; op1 = 2'd2;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      step();
      chk("no_double_gnt", 32'(gnt0 & gnt1), 32'd0);
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    chk("rr_count", 32'(order.size()), 32'd4);
    foreach (order[i]) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
    req0 = 1'b0; req1 = 1'b0;
    step(); step(); step();

    // Operand change after gnt1 must not affect the result.
    a1 = 4'b1100; b1 = 4'b1010; op1 = 2'd2; req1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin step(); seen = gnt1; end
    if (!seen) chk("gnt1_timeout", 32'd0, 32'd1);
    req1 = 1'b0; a1 = 4'b1111; b1 = 4'b0000;
    step();
    chk("captured_only", 32'({done1, result}), 32'b1_0110);
    step();

    // Reset during EXEC: outputs clear at once, no done, tie goes to 0.
    a0 = 4'b1111; b0 = 4'b1111; op0 = 2'd0; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin step(); seen = gnt0; end
    if (!seen) chk("gnt0_timeout", 32'd0, 32'd1);
    req0 = 1'b0;
    #1;
    do_reset();
    chk("post_reset_result", 32'(result), 32'd0);
    step();
    chk("no_done_after_abort", 32'({done0, done1}), 32'd0);
    a1 = 4'b0001; b1 = 4'b0001; op1 = 2'd0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk("tie_after_reset", 32'({gnt0, gnt1}), 32'b10);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // req1 pulsed only during DONE of a requester-0 operation is ignored.
    a0 = 4'b1010; b0 = 4'b0110; op0 = 2'd1; req0 = 1'b1;
    step();
    req0 = 1'b0;
    step();
    req1 = 1'b1;
    step();
    chk("ignored_in_done", 32'(gnt1), 32'd0);
    req1 = 1'b0;
    step();
    chk("no_late_gnt1", 32'(gnt1), 32'd0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req0 = ($urandom_range(0, 2) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      a0 = W'($urandom); b0 = W'($urandom); op0 = 2'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); op1 = 2'($urandom);
      step();
      chk("pulse_excl", 32'((gnt0 & gnt1) | (done0 & done1) | ((gnt0 | gnt1) & (done0 | done1))), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
